// File: rtl/uart_reg_pkg.sv
// uart_reg_pkg: shared types and frame constants for the UART register-bus controller
package uart_reg_pkg;
    typedef enum logic [1:0] {IDLE, BUS, RESP, WAIT} state_e;
    localparam logic [7:0] FRAME_HDR = 8'hAA;
    localparam logic [7:0] ST_OK     = 8'h77;
    localparam logic [7:0] ST_TMO    = 8'hEE;
    localparam logic [7:0] FRAME_T0  = 8'h00;
    localparam logic [7:0] FRAME_T1  = 8'hFF;
    localparam int         FRAME_LEN = 10;
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [15:0] data;
    } cmd_t;
    function automatic logic [7:0] frame_byte(input logic [3:0] idx, input logic [7:0] status,
                                              input logic [31:0] addr, input logic [15:0] rdata);
        logic [79:0] f;
        f = {FRAME_HDR, status, addr, rdata, FRAME_T0, FRAME_T1};
        return f[8*(9-idx) +: 8];
    endfunction
endpackage

// File: rtl/uart_reg_bus_ctrl_fifo.sv
// cmd_fifo: synchronous command FIFO; a push into a full FIFO is accepted only alongside a pop
module cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 49
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    logic [W-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] cnt_q;
    logic push_ok, pop_ok;
    assign full    = cnt_q == (AW+1)'(DEPTH);
    assign empty   = cnt_q == '0;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem_q[rd_q];
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_q] <= din;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push_ok) wr_q <= wr_q + 1'b1;
            if (pop_ok)  rd_q <= rd_q + 1'b1;
            cnt_q <= cnt_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end
endmodule

// File: rtl/uart_reg_bus_ctrl.sv
// uart_reg_bus_ctrl: queues decoder commands, runs them on the register bus with timeout,
// and returns read results / timeouts as 10-byte frames through the UART transmitter
module uart_reg_bus_ctrl
    import uart_reg_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_wr_en,
    input  logic [31:0] cmd_wr_addr,
    input  logic [15:0] cmd_wr_data,
    input  logic        cmd_rd_en,
    input  logic [31:0] cmd_rd_addr,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [15:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    output logic        fifo_full,
    output logic [7:0]  err_cnt
);
    state_e state_q, state_d;
    cmd_t cmd_q, cmd_d, push_cmd, fifo_dout;
    logic [7:0] timer_q, timer_d, status_q, status_d, tx_data_q, tx_data_d, err_q, err_d;
    logic [15:0] rdata_q, rdata_d;
    logic [3:0] idx_q, idx_d;
    logic guard_q, guard_d, tx_start_q, tx_start_d;
    logic fifo_empty, pop, tmo;
    logic [1:0] drops;
    logic [9:0] err_sum;
    assign push_cmd = cmd_wr_en ? '{1'b1, cmd_wr_addr, cmd_wr_data} : '{1'b0, cmd_rd_addr, 16'h0};
    assign pop      = state_q == IDLE && !fifo_empty;
    cmd_fifo #(.DEPTH(FIFO_DEPTH), .W(49)) u_fifo (
        .clk(clk), .reset_n(reset_n), .push(cmd_wr_en | cmd_rd_en), .pop(pop),
        .din(push_cmd), .dout(fifo_dout), .full(fifo_full), .empty(fifo_empty)
    );
    // a simultaneous read is always dropped; a push into a full FIFO survives only with a pop
    assign drops   = {1'b0, cmd_wr_en & cmd_rd_en} + {1'b0, (cmd_wr_en | cmd_rd_en) & fifo_full & ~pop};
    assign tmo     = state_q == BUS && !bus_ack && timer_q == 8'(TIMEOUT - 1);
    assign err_sum = {2'b0, err_q} + {8'b0, drops} + {9'b0, tmo};
    assign err_d   = err_sum > 10'd255 ? 8'hFF : err_sum[7:0];
    always_comb begin
        state_d    = state_q;
        cmd_d      = cmd_q;
        timer_d    = timer_q;
        status_d   = status_q;
        rdata_d    = rdata_q;
        idx_d      = idx_q;
        guard_d    = 1'b0;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        case (state_q)
            IDLE: if (!fifo_empty) begin
                cmd_d   = fifo_dout;
                timer_d = '0;
                idx_d   = '0;
                state_d = BUS;
            end
            BUS: if (bus_ack) begin
                rdata_d  = bus_rdata;
                status_d = ST_OK;
                state_d  = cmd_q.we ? IDLE : RESP;
            end else if (tmo) begin
                rdata_d  = '0;
                status_d = ST_TMO;
                state_d  = RESP;
            end else begin
                timer_d = timer_q + 8'd1;
            end
            RESP: if (!tx_busy) begin
                tx_start_d = 1'b1;
                tx_data_d  = frame_byte(idx_q, status_q, cmd_q.addr, rdata_q);
                guard_d    = 1'b1;
                state_d    = WAIT;
            end
            WAIT: if (!guard_q && !tx_busy) begin
                idx_d   = idx_q + 4'd1;
                state_d = idx_q == 4'(FRAME_LEN - 1) ? IDLE : RESP;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cmd_q      <= '0;
            timer_q    <= '0;
            status_q   <= '0;
            rdata_q    <= '0;
            idx_q      <= '0;
            guard_q    <= 1'b0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            err_q      <= '0;
        end else begin
            state_q    <= state_d;
            cmd_q      <= cmd_d;
            timer_q    <= timer_d;
            status_q   <= status_d;
            rdata_q    <= rdata_d;
            idx_q      <= idx_d;
            guard_q    <= guard_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            err_q      <= err_d;
        end
    end
    assign bus_req   = state_q == BUS;
    assign bus_we    = cmd_q.we;
    assign bus_addr  = cmd_q.addr;
    assign bus_wdata = cmd_q.data;
    assign tx_start  = tx_start_q;
    assign tx_data   = tx_data_q;
    assign err_cnt   = err_q;
endmodule

// File: tb/tb_uart_reg_bus_ctrl.sv
// tb_uart_reg_bus_ctrl: directed vector table plus overflow and reset-mid-frame sequences
module tb_uart_reg_bus_ctrl;
    logic clk = 1'b0, reset_n = 1'b0;
    logic cmd_wr_en = 1'b0, cmd_rd_en = 1'b0;
    logic [31:0] cmd_wr_addr = '0, cmd_rd_addr = '0;
    logic [15:0] cmd_wr_data = '0;
    logic bus_req, bus_we, bus_ack = 1'b0;
    logic [31:0] bus_addr;
    logic [15:0] bus_wdata, bus_rdata = '0;
    logic tx_start, tx_busy = 1'b0, fifo_full;
    logic [7:0] tx_data, err_cnt;

    always #5 clk = ~clk;

    uart_reg_bus_ctrl #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_wr_en(cmd_wr_en), .cmd_wr_addr(cmd_wr_addr), .cmd_wr_data(cmd_wr_data),
        .cmd_rd_en(cmd_rd_en), .cmd_rd_addr(cmd_rd_addr),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .fifo_full(fifo_full), .err_cnt(err_cnt)
    );

    int errors = 0, checks = 0;

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // bus responder: acks on the ack_n-th req cycle (0 = never), optional stray ack while idle
    int ack_n = 0, req_cnt = 0, last_len = 0;
    logic stray = 1'b0;
    logic [15:0] rd_val = '0;
    logic [48:0] obs [$];
    always @(negedge clk) begin
        if (bus_req) begin
            req_cnt++;
            if (req_cnt == 1) obs.push_back({bus_we, bus_addr, bus_wdata});
            bus_ack = ack_n != 0 && req_cnt == ack_n;
            last_len = req_cnt;
        end else begin
            req_cnt = 0;
            bus_ack = stray;
        end
        bus_rdata = bus_ack ? rd_val : 16'hDEAD;
    end

    // UART TX model: busy for 3 cycles per byte; flags starts while busy or data changing while busy
    int busy_cnt = 0, viol = 0;
    logic [7:0] cur = '0;
    logic [7:0] frm [$];
    always @(negedge clk) begin
        if (!reset_n) busy_cnt = 0;
        else if (tx_start) begin
            if (busy_cnt != 0) viol++;
            frm.push_back(tx_data);
            cur = tx_data;
            busy_cnt = 3;
        end else if (busy_cnt != 0) begin
            if (tx_data !== cur) viol++;
            busy_cnt--;
        end
        tx_busy = busy_cnt != 0;
    end

    task automatic do_reset();
        @(posedge clk); #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    task automatic send(input logic we, input logic both, input logic [31:0] addr, input logic [15:0] wd);
        @(posedge clk); #1;
        cmd_wr_en   = we | both;
        cmd_wr_addr = addr;
        cmd_wr_data = wd;
        cmd_rd_en   = !we | both;
        cmd_rd_addr = both ? addr + 32'h10 : addr;
        @(posedge clk); #1;
        cmd_wr_en = 1'b0;
        cmd_rd_en = 1'b0;
    endtask

    function automatic logic [79:0] pack_frame(input int base, input int n);
        logic [79:0] f = '0;
        for (int k = 0; k < n; k++) f = {f[71:0], frm[base+k]};
        return f;
    endfunction

    typedef struct {
        logic        we;
        logic        both;
        logic [31:0] addr;
        logic [15:0] wdata;
        int          ack;
        logic [15:0] rdata;
        int          len;
        logic        resp;
        logic [79:0] frame;
        logic [7:0]  err;
    } vec_t;
    vec_t v [6];

    initial begin
        int ob, fb, n;
        logic full_seen;
        v[0] = '{1, 0, 32'h00001234, 16'hBEEF, 3, 16'h0000, 3, 0, 80'h0, 8'd0};
        v[1] = '{0, 0, 32'h10000004, 16'h0000, 2, 16'h5A5A, 2, 1, 80'hAA77_10000004_5A5A_00FF, 8'd0};
        v[2] = '{0, 0, 32'hCAFE0010, 16'h0000, 0, 16'h9999, 8, 1, 80'hAAEE_CAFE0010_0000_00FF, 8'd1};
        v[3] = '{0, 1, 32'h00000020, 16'h1111, 1, 16'h0000, 1, 0, 80'h0, 8'd1};
        v[4] = '{1, 0, 32'h00000044, 16'h55AA, 0, 16'h0000, 8, 1, 80'hAAEE_00000044_0000_00FF, 8'd1};
        v[5] = '{0, 0, 32'hFFFFFFFF, 16'h0000, 8, 16'h1234, 8, 1, 80'hAA77_FFFFFFFF_1234_00FF, 8'd0};

        repeat (2) @(posedge clk);
        #1 chk("reset_outputs", 80'({bus_req, bus_we, bus_addr, bus_wdata, tx_start, tx_data, fifo_full, err_cnt}), 80'h0);
        reset_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            do_reset();
            ack_n  = v[i].ack;
            rd_val = v[i].rdata;
            stray  = i == 0;
            ob = obs.size();
            fb = frm.size();
            send(v[i].we, v[i].both, v[i].addr, v[i].wdata);
            repeat (150) @(posedge clk);
            #2;
            stray = 1'b0;
            chk_i($sformatf("v%0d_txn_count", i), obs.size() - ob, 1);
            if (obs.size() > ob)
                chk($sformatf("v%0d_txn", i), 80'(obs[ob]),
                    80'({v[i].we | v[i].both, v[i].addr, (v[i].we | v[i].both) ? v[i].wdata : 16'h0}));
            chk_i($sformatf("v%0d_req_len", i), last_len, v[i].len);
            chk_i($sformatf("v%0d_frame_len", i), frm.size() - fb, v[i].resp ? 10 : 0);
            if (v[i].resp && frm.size() - fb == 10)
                chk($sformatf("v%0d_frame", i), pack_frame(fb, 10), v[i].frame);
            chk($sformatf("v%0d_err_cnt", i), 80'(err_cnt), 80'(v[i].err));
        end

        // overflow: W0 stalls the bus while W1..W6 arrive; W5 and W6 find the FIFO full
        do_reset();
        ack_n = 6;
        ob = obs.size();
        full_seen = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(posedge clk); #1;
            if (fifo_full) full_seen = 1'b1;
            cmd_wr_en   = 1'b1;
            cmd_wr_addr = 32'h100 + 32'(k);
            cmd_wr_data = 16'(k);
        end
        @(posedge clk); #1 cmd_wr_en = 1'b0;
        chk("ovf_full_seen", 80'(full_seen), 80'h1);
        repeat (200) @(posedge clk);
        #2;
        chk_i("ovf_txn_count", obs.size() - ob, 5);
        for (int k = 0; k < 5; k++)
            if (obs.size() > ob + k)
                chk($sformatf("ovf_txn%0d", k), 80'(obs[ob+k]), 80'({1'b1, 32'h100 + 32'(k), 16'(k)}));
        chk("ovf_err_cnt", 80'(err_cnt), 80'd2);
        chk("ovf_full_clear", 80'(fifo_full), 80'h0);

        // reset during the 5th response byte, then a clean read
        do_reset();
        ack_n  = 1;
        rd_val = 16'hC0DE;
        send(1, 1, 32'h0BADF00D, 16'h7777);
        fb = frm.size();
        send(0, 0, 32'h0BADF00D, 16'h0);
        n = 0;
        while (frm.size() < fb + 5 && n < 300) begin
            @(posedge clk);
            n++;
        end
        chk_i("rst_reached_5th", frm.size() - fb, 5);
        if (frm.size() - fb == 5) chk("rst_first5", pack_frame(fb, 5), 80'hAA770BADF0);
        chk("rst_err_before", 80'(err_cnt), 80'd1);
        #1 reset_n = 1'b0;
        #1 chk("rst_immediate", 80'({tx_start, bus_req, err_cnt}), 80'h0);
        @(posedge clk); @(posedge clk); #1 reset_n = 1'b1;
        ack_n  = 2;
        rd_val = 16'h2468;
        fb = frm.size();
        send(0, 0, 32'h13579BDF, 16'h0);
        repeat (150) @(posedge clk);
        #2;
        chk_i("rst_after_frame_len", frm.size() - fb, 10);
        if (frm.size() - fb == 10) chk("rst_after_frame", pack_frame(fb, 10), 80'hAA77_13579BDF_2468_00FF);
        chk("rst_after_err", 80'(err_cnt), 80'h0);
        chk_i("tx_handshake_violations", viol, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
